mem_port_arbiter: RTL and testbench

- Shares the single unified memory between instruction fetch (IF) and the data-memory stage (DM).
- Replaces the clock-level address mux with a registered request/grant/response protocol, so memory may take multiple cycles.
- Supplies per-requester stall signals to the pipeline control.
- Sits between the pipeline and the Memory block.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_port_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified-memory port arbiter: FSM states,
// requester identifiers and the word-access func3 used for fetches.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } state_t;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_DM = 1'b1;

    localparam logic [2:0] FUNC3_WORD = 3'b010;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified memory between instruction fetch and the data
// stage using a registered request/grant/response handshake with timeout.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_DM_STREAK  = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic [2:0]  dm_func3,
    output logic        dm_gnt,
    output logic        dm_rvalid,
    output logic [31:0] dm_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_func3,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        bus_err,
    output logic        stall_if,
    output logic        stall_dm
);

    localparam int STREAK_W = (MAX_DM_STREAK > 0) ? $clog2(MAX_DM_STREAK + 1) : 1;
    localparam int TIMER_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_STREAK);
    localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    state_t              state_reg, state_next;
    logic [STREAK_W-1:0] streak_reg, streak_next;
    logic [TIMER_W-1:0]  timer_reg, timer_next;

    logic        mem_req_reg, mem_req_next;
    logic        mem_we_reg, mem_we_next;
    logic [31:0] mem_addr_reg, mem_addr_next;
    logic [31:0] mem_wdata_reg, mem_wdata_next;
    logic [2:0]  mem_func3_reg, mem_func3_next;

    logic        if_gnt_reg, if_gnt_next;
    logic        dm_gnt_reg, dm_gnt_next;
    logic        if_rvalid_reg, if_rvalid_next;
    logic        dm_rvalid_reg, dm_rvalid_next;
    logic [31:0] if_rdata_reg, if_rdata_next;
    logic [31:0] dm_rdata_reg, dm_rdata_next;
    logic        bus_err_reg, bus_err_next;

    // A request still high during its own rvalid cycle is the old one, not a new one.
    logic if_elig, dm_elig;
    assign if_elig = if_req & ~if_rvalid_reg;
    assign dm_elig = dm_req & ~dm_rvalid_reg;

    logic        winner;
    logic [31:0] resp_data;

    always_comb begin
        state_next     = state_reg;
        streak_next    = streak_reg;
        timer_next     = timer_reg;
        mem_req_next   = mem_req_reg;
        mem_we_next    = mem_we_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        mem_func3_next = mem_func3_reg;
        if_gnt_next    = 1'b0;
        dm_gnt_next    = 1'b0;
        if_rvalid_next = 1'b0;
        dm_rvalid_next = 1'b0;
        bus_err_next   = 1'b0;
        if_rdata_next  = if_rdata_reg;
        dm_rdata_next  = dm_rdata_reg;
        winner         = REQ_IF;
        resp_data      = 32'd0;

        case (state_reg)
            IDLE: begin
                if (dm_elig && !(if_elig && streak_reg == STREAK_MAX)) begin
                    winner         = REQ_DM;
                    state_next     = BUSY_DM;
                    dm_gnt_next    = 1'b1;
                    mem_req_next   = 1'b1;
                    mem_we_next    = dm_we;
                    mem_addr_next  = dm_addr;
                    mem_wdata_next = dm_wdata;
                    mem_func3_next = dm_func3;
                    timer_next     = '0;
                    if (if_elig) begin
                        if (streak_reg != STREAK_MAX) begin
                            streak_next = streak_reg + 1'b1;
                        end
                    end else if (!if_req) begin
                        streak_next = '0;
                    end
                end else if (if_elig) begin
                    winner         = REQ_IF;
                    state_next     = BUSY_IF;
                    if_gnt_next    = 1'b1;
                    mem_req_next   = 1'b1;
                    mem_we_next    = 1'b0;
                    mem_addr_next  = if_addr;
                    mem_wdata_next = 32'd0;
                    mem_func3_next = FUNC3_WORD;
                    timer_next     = '0;
                    streak_next    = '0;
                end
            end
            BUSY_IF, BUSY_DM: begin
                // mem_ready in the last allowed cycle still completes normally.
                if (mem_ready || timer_reg == TIMER_LAST) begin
                    state_next   = IDLE;
                    mem_req_next = 1'b0;
                    bus_err_next = ~mem_ready;
                    if (mem_ready && !mem_we_reg) begin
                        resp_data = mem_rdata;
                    end
                    if (state_reg == BUSY_IF) begin
                        if_rvalid_next = 1'b1;
                        if_rdata_next  = resp_data;
                    end else begin
                        dm_rvalid_next = 1'b1;
                        dm_rdata_next  = resp_data;
                    end
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            default: begin
                state_next   = IDLE;
                mem_req_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= IDLE;
            streak_reg    <= '0;
            timer_reg     <= '0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= 32'd0;
            mem_wdata_reg <= 32'd0;
            mem_func3_reg <= 3'd0;
            if_gnt_reg    <= 1'b0;
            dm_gnt_reg    <= 1'b0;
            if_rvalid_reg <= 1'b0;
            dm_rvalid_reg <= 1'b0;
            if_rdata_reg  <= 32'd0;
            dm_rdata_reg  <= 32'd0;
            bus_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            streak_reg    <= streak_next;
            timer_reg     <= timer_next;
            mem_req_reg   <= mem_req_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            mem_func3_reg <= mem_func3_next;
            if_gnt_reg    <= if_gnt_next;
            dm_gnt_reg    <= dm_gnt_next;
            if_rvalid_reg <= if_rvalid_next;
            dm_rvalid_reg <= dm_rvalid_next;
            if_rdata_reg  <= if_rdata_next;
            dm_rdata_reg  <= dm_rdata_next;
            bus_err_reg   <= bus_err_next;
        end
    end

    assign if_gnt    = if_gnt_reg;
    assign dm_gnt    = dm_gnt_reg;
    assign if_rvalid = if_rvalid_reg;
    assign dm_rvalid = dm_rvalid_reg;
    assign if_rdata  = if_rdata_reg;
    assign dm_rdata  = dm_rdata_reg;
    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_func3 = mem_func3_reg;
    assign bus_err   = bus_err_reg;
    assign stall_if  = if_req & ~if_rvalid_reg;
    assign stall_dm  = dm_req & ~dm_rvalid_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_mem_port_arbiter;

    localparam int MAXS = 2;
    localparam int TMO  = 4;

    logic        clk, rst;
    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_gnt, dm_rvalid;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [2:0]  dm_func3;
    logic        mem_req, mem_we, mem_ready, bus_err, stall_if, stall_dm;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_func3;

    mem_port_arbiter #(.MAX_DM_STREAK(MAXS), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_func3(dm_func3), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_func3(mem_func3), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .bus_err(bus_err), .stall_if(stall_if), .stall_dm(stall_dm)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: who owns memory, how long it has waited, and the DM win streak.
    int          m_owner;   // 0 none, 1 fetch, 2 data
    int          m_waited;
    int          m_streak;
    logic        m_if_gnt, m_dm_gnt, m_if_rvalid, m_dm_rvalid, m_bus_err;
    logic        m_mem_req, m_mem_we;
    logic [31:0] m_mem_addr, m_mem_wdata, m_if_rdata, m_dm_rdata;
    logic [2:0]  m_mem_func3;
    bit          started = 0;

    initial begin
        forever begin
            bit ie, de, dm_takes;
            logic [31:0] data;
            @(posedge clk);
            ie = if_req && !m_if_rvalid;
            de = dm_req && !m_dm_rvalid;
            m_if_gnt = 0; m_dm_gnt = 0; m_if_rvalid = 0; m_dm_rvalid = 0; m_bus_err = 0;
            if (!rst) begin
                m_owner = 0; m_waited = 0; m_streak = 0; m_mem_req = 0;
                m_if_rdata = 0; m_dm_rdata = 0;
            end else if (m_owner == 0) begin
                dm_takes = de && (!ie || m_streak < MAXS);
                if (dm_takes) begin
                    m_owner = 2; m_dm_gnt = 1;
                    m_mem_we = dm_we; m_mem_addr = dm_addr;
                    m_mem_wdata = dm_wdata; m_mem_func3 = dm_func3;
                    if (ie) m_streak = (m_streak + 1 > MAXS) ? MAXS : m_streak + 1;
                    else if (!if_req) m_streak = 0;
                end else if (ie) begin
                    m_owner = 1; m_if_gnt = 1; m_streak = 0;
                    m_mem_we = 0; m_mem_addr = if_addr; m_mem_wdata = 0; m_mem_func3 = 3'b010;
                end
                if (m_owner != 0) begin
                    m_mem_req = 1; m_waited = 0;
                end
            end else begin
                if (mem_ready || m_waited + 1 >= TMO) begin
                    data = (mem_ready && !m_mem_we) ? mem_rdata : 32'd0;
                    m_bus_err = !mem_ready;
                    if (m_owner == 1) begin m_if_rvalid = 1; m_if_rdata = data; end
                    else begin m_dm_rvalid = 1; m_dm_rdata = data; end
                    m_owner = 0; m_mem_req = 0;
                end else begin
                    m_waited++;
                end
            end
            started = 1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                check("if_gnt", 32'(if_gnt), 32'(m_if_gnt));
                check("dm_gnt", 32'(dm_gnt), 32'(m_dm_gnt));
                check("if_rvalid", 32'(if_rvalid), 32'(m_if_rvalid));
                check("dm_rvalid", 32'(dm_rvalid), 32'(m_dm_rvalid));
                check("bus_err", 32'(bus_err), 32'(m_bus_err));
                check("mem_req", 32'(mem_req), 32'(m_mem_req));
                check("stall_if", 32'(stall_if), 32'(if_req && !m_if_rvalid));
                check("stall_dm", 32'(stall_dm), 32'(dm_req && !m_dm_rvalid));
                if (m_mem_req) begin
                    check("mem_we", 32'(mem_we), 32'(m_mem_we));
                    check("mem_addr", mem_addr, m_mem_addr);
                    check("mem_wdata", mem_wdata, m_mem_wdata);
                    check("mem_func3", 32'(mem_func3), 32'(m_mem_func3));
                end
                if (m_if_rvalid) check("if_rdata", if_rdata, m_if_rdata);
                if (m_dm_rvalid) check("dm_rdata", dm_rdata, m_dm_rdata);
            end
        end
    end

    // Memory responder: answers ready_delay cycles into each request (99 = never).
    int          ready_delay = 0;
    int          busy_n = 0;
    logic        prev_req = 1'b0;
    logic [31:0] rdata_value = 32'd0;

    task automatic step();
        @(posedge clk);
        #1;
        if (mem_req && !prev_req) busy_n = 0;
        else if (mem_req) busy_n++;
        prev_req  = mem_req;
        mem_ready = mem_req && (busy_n == ready_delay);
        mem_rdata = rdata_value;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int          req_cycles, n;
        logic [5:0]  seq;
        rst = 0; if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0;
        dm_addr = 0; dm_wdata = 0; dm_func3 = 0; mem_ready = 0; mem_rdata = 0;
        idle(2);
        rst = 1;
        step();
        check("reset_mem_req", 32'(mem_req), 32'd0);
        check("reset_rvalid", 32'({if_rvalid, dm_rvalid, bus_err}), 32'd0);

        // Lone fetch
        ready_delay = 0; rdata_value = 32'h0050_0093;
        if_req = 1; if_addr = 32'h40;
        step();
        check("fetch_gnt", 32'(if_gnt), 32'd1);
        check("fetch_addr", mem_addr, 32'h40);
        check("fetch_func3", 32'(mem_func3), 32'd2);
        step();
        check("fetch_rvalid", 32'(if_rvalid), 32'd1);
        check("fetch_rdata", if_rdata, 32'h0050_0093);
        check("fetch_stall_low", 32'(stall_if), 32'd0);
        if_req = 0;
        idle(2);

        // Collision: DM first, IF next
        rdata_value = 32'hCAFE_0001;
        if_req = 1; if_addr = 32'h80;
        dm_req = 1; dm_we = 0; dm_addr = 32'h100; dm_func3 = 3'b010;
        step();
        check("coll_dm_first", 32'({if_gnt, dm_gnt}), 32'b01);
        check("coll_stall_if1", 32'(stall_if), 32'd1);
        step();
        check("coll_dm_rvalid", 32'(dm_rvalid), 32'd1);
        check("coll_stall_if2", 32'(stall_if), 32'd1);
        dm_req = 0;
        step();
        check("coll_if_gnt", 32'(if_gnt), 32'd1);
        check("coll_if_addr", mem_addr, 32'h80);
        check("coll_stall_if3", 32'(stall_if), 32'd1);
        step();
        check("coll_if_rvalid", 32'(if_rvalid), 32'd1);
        if_req = 0;
        idle(2);

        // Store
        dm_req = 1; dm_we = 1; dm_addr = 32'h20; dm_wdata = 32'hDEAD_BEEF; dm_func3 = 3'b000;
        step();
        check("store_we", 32'(mem_we), 32'd1);
        check("store_addr", mem_addr, 32'h20);
        check("store_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("store_func3", 32'(mem_func3), 32'd0);
        step();
        check("store_rvalid", 32'(dm_rvalid), 32'd1);
        check("store_rdata", dm_rdata, 32'd0);
        dm_req = 0; dm_we = 0;
        idle(2);

        // Timeout, then a response landing in the last allowed cycle
        for (int run = 0; run < 2; run++) begin
            ready_delay = (run == 0) ? 99 : TMO - 1;
            rdata_value = 32'h1234_5678;
            dm_req = 1; dm_addr = 32'h300; dm_func3 = 3'b010;
            step();
            check("tmo_gnt", 32'(dm_gnt), 32'd1);
            dm_req = 0;
            req_cycles = 1;
            for (int i = 0; i < 12; i++) begin
                step();
                if (dm_rvalid) break;
                if (mem_req) req_cycles++;
            end
            check("tmo_req_cycles", 32'(req_cycles), 32'(TMO));
            check("tmo_rvalid", 32'(dm_rvalid), 32'd1);
            check("tmo_bus_err", 32'(bus_err), (run == 0) ? 32'd1 : 32'd0);
            check("tmo_rdata", dm_rdata, (run == 0) ? 32'd0 : 32'h1234_5678);
            idle(2);
        end

        // Reset while a fetch is outstanding
        ready_delay = 99;
        if_req = 1; if_addr = 32'h44;
        step();
        check("rst_pre_gnt", 32'(if_gnt), 32'd1);
        step();
        rst = 0;
        step();
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_no_rvalid", 32'(if_rvalid), 32'd0);
        rst = 1; ready_delay = 0;
        step();
        check("rst_fresh_gnt", 32'(if_gnt), 32'd1);
        step();
        check("rst_fresh_rvalid", 32'(if_rvalid), 32'd1);
        if_req = 0;
        idle(2);

        // Streak limit with requests re-raised as soon as each response is seen
        dm_req = 1; dm_we = 0; dm_addr = 32'h200;
        if_req = 1; if_addr = 32'h300;
        seq = '0; n = 0;
        for (int i = 0; i < 60 && n < 6; i++) begin
            step();
            if (if_gnt) begin seq[n] = 1'b1; n++; end
            else if (dm_gnt) begin seq[n] = 1'b0; n++; end
            dm_req = !if_rvalid;
            if_req = !dm_rvalid;
        end
        check("streak_grant_count", 32'(n), 32'd6);
        check("streak_sequence", 32'(seq), 32'b100100);
        dm_req = 0; if_req = 0;
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
